// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module  : axi4_lite_pkg
// Brief   : Shared AXI4-Lite types, master FSM states and protection default.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } axim_state_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Error responses are exactly those with RESP[1] set.
  function automatic logic resp_is_err(input axi_resp_e resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite_master.sv
// ============================================================================
// Module  : axi4_lite_master
// Brief   : Single-outstanding AXI4-Lite initiator driven by a cmd/rsp port.
//           Optional macro AXIM_WSTRB_EN adds the i_cmd_wstrb port.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  // command / response
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
`ifdef AXIM_WSTRB_EN
  input  logic [3:0]        i_cmd_wstrb,
`endif
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  // write address
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              AWVALID,
  input  logic              AWREADY,
  // write data
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  // write response
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // read address
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,
  // read data
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("axi4_lite_master: DATA_W must be 32");
  end

  axim_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef AXIM_WSTRB_EN
  logic [3:0]        wstrb_q, wstrb_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = 1'b0;
    arvalid_d   = arvalid_q;
    rready_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef AXIM_WSTRB_EN
    wstrb_d     = wstrb_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
`ifdef AXIM_WSTRB_EN
          wstrb_d = i_cmd_wstrb;
`endif
          if (i_cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end

      // AW and W complete independently; B waits for both.
      ST_WR_REQ: begin
        if (awvalid_q && AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (BVALID) begin
          rsp_err_d   = resp_is_err(axi_resp_e'(BRESP));
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else begin
          bready_d = 1'b1;
        end
      end

      ST_RD_REQ: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (RVALID) begin
          rsp_err_d   = resp_is_err(axi_resp_e'(RRESP));
          rsp_rdata_d = RDATA;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else begin
          rready_d = 1'b1;
        end
      end

      ST_RSP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef AXIM_WSTRB_EN
      wstrb_q     <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef AXIM_WSTRB_EN
      wstrb_q     <= wstrb_d;
`endif
    end
  end

  // Ready is forced low while reset is asserted, not just after it lands.
  assign o_cmd_ready = (state_q == ST_IDLE) && ARSTn;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

  assign AWADDR  = addr_q;
  assign AWPROT  = AXI_PROT_DEFAULT;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARADDR  = addr_q;
  assign ARPROT  = AXI_PROT_DEFAULT;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

`ifdef AXIM_WSTRB_EN
  assign WSTRB = wstrb_q;
`else
  assign WSTRB = 4'hF;
`endif

endmodule

`default_nettype wire
